// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache with one-cycle load latency.
// Misses stall the core while the line is written back and refilled over a 128-bit valid/ready port.
module dcache_direct_mapped #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  cpu_addr,
    input  logic         cpu_re,
    input  logic [3:0]   cpu_we,
    input  logic [31:0]  cpu_din,
    output logic [31:0]  cpu_dout,
    output logic         stall,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic         mem_req_rw,
    output logic [27:0]  mem_req_addr,
    output logic [127:0] mem_req_data,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
);
    localparam int LINE_BITS = LINE_WORDS * 32;
    localparam int IDXB      = $clog2(NUM_LINES);
    localparam int TAGB      = 28 - IDXB;

    typedef enum logic [2:0] {IDLE, WB_REQ, RF_REQ, RF_WAIT, REPLAY} state_t;

    // mem_req_* is a valid/ready channel: fields are registered, held stable while valid is high,
    // and the transfer happens on the rising edge where valid && ready.
    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic [LINE_BITS-1:0]  data_mem [NUM_LINES];
    logic [TAGB-1:0]       tag_mem  [NUM_LINES];

    logic                  req_valid_q, req_valid_d;
    logic [27:0]           req_line_q, req_line_d;
    logic [1:0]            req_off_q, req_off_d;
    logic [3:0]            req_we_q, req_we_d;
    logic [31:0]           req_din_q, req_din_d;
    logic [LINE_BITS-1:0]  line_q, line_d;
    logic [TAGB-1:0]       tag_rd_q, tag_rd_d;
    logic                  valid_rd_q, valid_rd_d, dirty_rd_q, dirty_rd_d;
    logic [31:0]           dout_q, dout_d;

    logic                  mem_req_valid_q, mem_req_valid_d, mem_req_rw_q, mem_req_rw_d;
    logic [27:0]           mem_req_addr_q, mem_req_addr_d;
    logic [127:0]          mem_req_data_q, mem_req_data_d;

    logic                  hit, miss, is_store, capture, fwd;
    logic                  arr_we, arr_dirty;
    logic [IDXB-1:0]       arr_idx, cpu_idx, req_idx;
    logic [TAGB-1:0]       req_tag;
    logic [LINE_BITS-1:0]  arr_line, refill_line;
    logic                  unused_addr_bits;

    function automatic logic [31:0] get_word(input logic [LINE_BITS-1:0] line, input logic [1:0] off);
        return line[int'(off)*32 +: 32];
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_word(input logic [LINE_BITS-1:0] line,
                                                        input logic [1:0] off, input logic [3:0] we,
                                                        input logic [31:0] din);
        logic [LINE_BITS-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[int'(off)*32 + b*8 +: 8] = din[b*8 +: 8];
        return r;
    endfunction

    assign unused_addr_bits = ^cpu_addr[1:0];
    assign cpu_idx  = cpu_addr[4+IDXB-1:4];
    assign req_idx  = req_line_q[IDXB-1:0];
    assign req_tag  = req_line_q[27:IDXB];
    assign is_store = |req_we_q;
    assign hit      = req_valid_q && valid_rd_q && (tag_rd_q == req_tag);
    assign miss     = req_valid_q && !hit;
    assign stall    = (state_q == IDLE && miss) || state_q == WB_REQ
                   || state_q == RF_REQ || state_q == RF_WAIT;
    assign capture  = state_q == IDLE && !stall && (cpu_re || |cpu_we);
    assign refill_line = is_store ? merge_word(mem_resp_data, req_off_q, req_we_q, req_din_q)
                                  : mem_resp_data;

    assign cpu_dout      = dout_d;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_rw    = mem_req_rw_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_data  = mem_req_data_q;

    always_comb begin
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_rw_d    = mem_req_rw_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_data_d  = mem_req_data_q;
        arr_we          = 1'b0;
        arr_dirty       = 1'b0;
        arr_idx         = req_idx;
        arr_line        = line_q;
        line_d          = line_q;
        dout_d          = dout_q;
        case (state_q)
            IDLE: begin
                if (hit && is_store) begin
                    arr_we    = 1'b1;
                    arr_dirty = 1'b1;
                    arr_line  = merge_word(line_q, req_off_q, req_we_q, req_din_q);
                end else if (hit) begin
                    dout_d = get_word(line_q, req_off_q);
                end else if (miss) begin
                    mem_req_valid_d = 1'b1;
                    if (valid_rd_q && dirty_rd_q) begin
                        state_d        = WB_REQ;
                        mem_req_rw_d   = 1'b1;
                        mem_req_addr_d = {tag_rd_q, req_idx};
                        mem_req_data_d = line_q;
                    end else begin
                        state_d        = RF_REQ;
                        mem_req_rw_d   = 1'b0;
                        mem_req_addr_d = req_line_q;
                    end
                end
            end
            WB_REQ: if (mem_req_ready) begin
                state_d        = RF_REQ;
                mem_req_rw_d   = 1'b0;
                mem_req_addr_d = req_line_q;
            end
            RF_REQ: if (mem_req_ready) begin
                state_d         = RF_WAIT;
                mem_req_valid_d = 1'b0;
            end
            RF_WAIT: if (mem_resp_valid) begin
                state_d   = REPLAY;
                arr_we    = 1'b1;
                arr_dirty = is_store;
                arr_line  = refill_line;
                line_d    = refill_line;
            end
            REPLAY: begin
                state_d = IDLE;
                if (!is_store) dout_d = get_word(line_q, req_off_q);
            end
            default: state_d = IDLE;
        endcase

        valid_d = valid_q;
        dirty_d = dirty_q;
        if (arr_we) begin
            valid_d[arr_idx] = 1'b1;
            dirty_d[arr_idx] = arr_dirty;
        end

        // A request captured while a store hit writes the same line must see the written line.
        fwd         = arr_we && arr_idx == cpu_idx;
        req_valid_d = capture;
        req_line_d  = req_line_q;
        req_off_d   = req_off_q;
        req_we_d    = req_we_q;
        req_din_d   = req_din_q;
        tag_rd_d    = tag_rd_q;
        valid_rd_d  = valid_rd_q;
        dirty_rd_d  = dirty_rd_q;
        if (capture) begin
            req_line_d = cpu_addr[31:4];
            req_off_d  = cpu_addr[3:2];
            req_we_d   = cpu_we;
            req_din_d  = cpu_din;
            line_d     = fwd ? arr_line : data_mem[cpu_idx];
            tag_rd_d   = fwd ? req_tag  : tag_mem[cpu_idx];
            valid_rd_d = fwd ? 1'b1     : valid_q[cpu_idx];
            dirty_rd_d = fwd ? 1'b1     : dirty_q[cpu_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_mem[arr_idx] <= arr_line;
            tag_mem[arr_idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            req_valid_q     <= 1'b0;
            req_line_q      <= '0;
            req_off_q       <= '0;
            req_we_q        <= '0;
            req_din_q       <= '0;
            line_q          <= '0;
            tag_rd_q        <= '0;
            valid_rd_q      <= 1'b0;
            dirty_rd_q      <= 1'b0;
            dout_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            req_valid_q     <= req_valid_d;
            req_line_q      <= req_line_d;
            req_off_q       <= req_off_d;
            req_we_q        <= req_we_d;
            req_din_q       <= req_din_d;
            line_q          <= line_d;
            tag_rd_q        <= tag_rd_d;
            valid_rd_q      <= valid_rd_d;
            dirty_rd_q      <= dirty_rd_d;
            dout_q          <= dout_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_rw_q    <= mem_req_rw_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_data_q  <= mem_req_data_d;
        end
    end
endmodule
